// File: rtl/rule110_host_sequencer_if.sv
// rtl/rule110_host_sequencer_if.sv - host command/stream and CA pin bundle for the rule110 host sequencer
`timescale 1ns/1ps
interface rule110_host_sequencer_if #(
  parameter int ADDR_BITS = 6,
  parameter int GEN_BITS  = 16
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [GEN_BITS-1:0]  cmd_arg;

  logic [7:0]           load_data;
  logic                 load_valid;
  logic                 load_ready;

  logic [7:0]           rd_data;
  logic                 rd_valid;
  logic                 rd_ready;

  logic                 busy;
  logic                 done;

  logic [7:0]           ca_data_in;
  logic                 ca_write_enable_n;
  logic                 ca_halt_n;
  logic [ADDR_BITS-1:0] ca_address;
  logic [7:0]           ca_data_out;

  // slave: the sequencer itself; master: host fabric plus the CA pins it talks to
  modport slave (
    input  cmd_valid, cmd_op, cmd_arg,
    input  load_data, load_valid,
    input  rd_ready,
    input  ca_data_out,
    output cmd_ready, load_ready,
    output rd_data, rd_valid,
    output busy, done,
    output ca_data_in, ca_write_enable_n, ca_halt_n, ca_address
  );

  modport master (
    output cmd_valid, cmd_op, cmd_arg,
    output load_data, load_valid,
    output rd_ready,
    output ca_data_out,
    input  cmd_ready, load_ready,
    input  rd_data, rd_valid,
    input  busy, done,
    input  ca_data_in, ca_write_enable_n, ca_halt_n, ca_address
  );
endinterface

// File: rtl/rule110_host_sequencer.sv
// rtl/rule110_host_sequencer.sv - turns LOAD/RUN/READ host commands into cycle-exact rule110 CA pin sequences
`timescale 1ns/1ps
module rule110_host_sequencer #(
  parameter int NUM_BLOCKS = 28,
  parameter int ADDR_BITS  = 6,
  parameter int GEN_BITS   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  rule110_host_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_READ_ADDR,
    S_READ_HOLD
  } state_t;

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_LOAD = 2'd1;
  localparam logic [1:0] OP_RUN  = 2'd2;
  localparam logic [1:0] OP_READ = 2'd3;

  localparam logic [ADDR_BITS-1:0] LAST_BLK = ADDR_BITS'(NUM_BLOCKS - 1);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);
  localparam logic [GEN_BITS-1:0]  CNT_ONE  = GEN_BITS'(1);

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] blk_q, blk_d;
  logic [GEN_BITS-1:0]  cnt_q, cnt_d;
  logic [7:0]           ca_data_in_q, ca_data_in_d;
  logic                 ca_we_n_q, ca_we_n_d;
  logic                 ca_halt_n_q, ca_halt_n_d;
  logic [ADDR_BITS-1:0] ca_address_q, ca_address_d;
  logic [7:0]           rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 done_q, done_d;

  logic load_fire;
  logic rd_fire;

  assign load_fire = bus.load_valid && (state_q == S_LOAD);
  assign rd_fire   = rd_valid_q && bus.rd_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      blk_q        <= '0;
      cnt_q        <= '0;
      ca_data_in_q <= '0;
      ca_we_n_q    <= 1'b1;
      ca_halt_n_q  <= 1'b0;
      ca_address_q <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      blk_q        <= blk_d;
      cnt_q        <= cnt_d;
      ca_data_in_q <= ca_data_in_d;
      ca_we_n_q    <= ca_we_n_d;
      ca_halt_n_q  <= ca_halt_n_d;
      ca_address_q <= ca_address_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    blk_d        = blk_q;
    cnt_d        = cnt_q;
    ca_data_in_d = ca_data_in_q;
    ca_we_n_d    = ca_we_n_q;
    ca_halt_n_d  = ca_halt_n_q;
    ca_address_d = ca_address_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = rd_valid_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        ca_we_n_d    = 1'b1;
        ca_halt_n_d  = 1'b0;
        ca_address_d = '0;
        ca_data_in_d = '0;
        blk_d        = '0;
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_NOP:  done_d = 1'b1;
            OP_LOAD: state_d = S_LOAD;
            OP_RUN: begin
              if (bus.cmd_arg == '0) begin
                done_d = 1'b1;
              end else begin
                // halt_n rises on the accept edge so the first run cycle is the next one
                state_d     = S_RUN;
                cnt_d       = bus.cmd_arg;
                ca_halt_n_d = 1'b1;
              end
            end
            OP_READ: state_d = S_READ_ADDR;
            default: state_d = S_IDLE;
          endcase
        end
      end

      S_LOAD: begin
        ca_halt_n_d = 1'b0;
        ca_we_n_d   = 1'b1;
        if (load_fire) begin
          ca_address_d = blk_q;
          ca_data_in_d = bus.load_data;
          ca_we_n_d    = 1'b0;
          if (blk_q == LAST_BLK) begin
            state_d = S_IDLE;
            blk_d   = '0;
            done_d  = 1'b1;
          end else begin
            blk_d = blk_q + ADDR_ONE;
          end
        end
      end

      S_RUN: begin
        ca_we_n_d = 1'b1;
        // cnt counts remaining high cycles; the zero cycle lets halt_n settle low before done
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            ca_halt_n_d = 1'b0;
          end
        end
      end

      S_READ_ADDR: begin
        ca_halt_n_d  = 1'b0;
        ca_we_n_d    = 1'b1;
        ca_address_d = blk_q;
        rd_data_d    = bus.ca_data_out;
        rd_valid_d   = 1'b1;
        state_d      = S_READ_HOLD;
      end

      S_READ_HOLD: begin
        ca_halt_n_d = 1'b0;
        if (rd_fire) begin
          rd_valid_d = 1'b0;
          if (blk_q == LAST_BLK) begin
            state_d = S_IDLE;
            blk_d   = '0;
            done_d  = 1'b1;
          end else begin
            blk_d        = blk_q + ADDR_ONE;
            ca_address_d = blk_q + ADDR_ONE;
            state_d      = S_READ_ADDR;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.cmd_ready         = (state_q == S_IDLE);
  assign bus.load_ready        = (state_q == S_LOAD);
  assign bus.busy              = (state_q != S_IDLE);
  assign bus.done              = done_q;
  assign bus.rd_data           = rd_data_q;
  assign bus.rd_valid          = rd_valid_q;
  assign bus.ca_data_in        = ca_data_in_q;
  assign bus.ca_write_enable_n = ca_we_n_q;
  assign bus.ca_halt_n         = ca_halt_n_q;
  assign bus.ca_address        = ca_address_q;

endmodule

// File: tb/tb_rule110_host_sequencer.sv
// tb/tb_rule110_host_sequencer.sv - directed bench for the rule110 host sequencer with a behavioural CA model
`timescale 1ns/1ps
module tb_rule110_host_sequencer;
  localparam int NB = 28;
  localparam int AB = 6;
  localparam int GB = 16;
  localparam int NC = NB * 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rule110_host_sequencer_if #(.ADDR_BITS(AB), .GEN_BITS(GB)) bus();

  rule110_host_sequencer #(.NUM_BLOCKS(NB), .ADDR_BITS(AB), .GEN_BITS(GB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // CA model: cell i has left neighbour i+1 and right neighbour i-1, zero beyond the ends
  logic [NC-1:0] cells;
  logic [NC-1:0] nxt;
  logic [NC-1:0] exp_img;
  int            gens;
  logic          model_clr;

  function automatic logic [NC-1:0] step(input logic [NC-1:0] c);
    logic [7:0]    rule;
    logic [NC-1:0] n;
    logic          l, r;
    rule = 8'd110;
    n    = '0;
    for (int i = 0; i < NC; i++) begin
      l    = (i < NC - 1) && c[(i + 1) % NC];
      r    = (i > 0) && c[(i + NC - 1) % NC];
      n[i] = rule[{l, c[i], r}];
    end
    return n;
  endfunction

  assign nxt = step(cells);

  always_comb begin
    bus.ca_data_out = 8'h00;
    if (int'(bus.ca_address) < NB) bus.ca_data_out = nxt[int'(bus.ca_address)*8 +: 8];
  end

  always @(posedge clk) begin
    if (model_clr) begin
      cells <= '0;
      gens  <= 0;
    end else if (!bus.ca_write_enable_n) begin
      if (int'(bus.ca_address) < NB) cells[int'(bus.ca_address)*8 +: 8] <= bus.ca_data_in;
    end else if (bus.ca_halt_n) begin
      cells <= nxt;
      gens  <= gens + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  logic [7:0] load_buf [NB];
  logic [7:0] rd_buf   [NB];

  task automatic clear_model();
    model_clr = 1'b1;
    @(negedge clk);
    model_clr = 1'b0;
  endtask

  task automatic do_load(input int gap_at, input int gap_len, input string tag);
    int   k, gap, last_addr, prev_blk, we_low, we_high_in, pin_err, dones, g0, cyc, mem_err;
    logic prev_acc;
    k = 0; gap = 0; last_addr = 0; prev_blk = 0; we_low = 0; we_high_in = 0;
    pin_err = 0; dones = 0; cyc = 0; mem_err = 0; prev_acc = 1'b0;
    g0 = gens;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1; bus.cmd_arg = '0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk({tag, "_load_ready"}, int'(bus.load_ready), 1);
    while ((k < NB || prev_acc) && cyc < 200) begin
      if (bus.done) dones++;
      if (bus.ca_halt_n) pin_err++;
      if (prev_acc) begin
        we_low++;
        if (bus.ca_write_enable_n || int'(bus.ca_address) != prev_blk ||
            bus.ca_data_in != load_buf[prev_blk]) pin_err++;
        last_addr = prev_blk;
        if (prev_blk == NB - 1) chk({tag, "_done_last"}, int'(bus.done), 1);
      end else begin
        if (!bus.ca_write_enable_n || int'(bus.ca_address) != last_addr) pin_err++;
        if (k > 0) we_high_in++;
      end
      if (k < NB && gap == 0) begin
        bus.load_valid = 1'b1;
        bus.load_data  = load_buf[k];
        prev_acc = 1'b1;
        prev_blk = k;
        if (k == gap_at) gap = gap_len;
        k++;
      end else begin
        bus.load_valid = 1'b0;
        prev_acc = 1'b0;
        if (gap > 0) gap--;
      end
      cyc++;
      @(negedge clk);
    end
    chk({tag, "_timeout"}, int'(cyc < 200), 1);
    chk({tag, "_we_low_cycles"}, we_low, NB);
    chk({tag, "_gap_cycles"}, we_high_in, gap_len);
    chk({tag, "_pin_errors"}, pin_err, 0);
    chk({tag, "_done_pulses"}, dones, 1);
    chk({tag, "_no_advance"}, gens - g0, 0);
    chk({tag, "_idle_we_n"}, int'(bus.ca_write_enable_n), 1);
    chk({tag, "_idle_addr"}, int'(bus.ca_address), 0);
    chk({tag, "_idle_busy"}, int'(bus.busy), 0);
    for (int i = 0; i < NB; i++) if (cells[i*8 +: 8] != load_buf[i]) mem_err++;
    chk({tag, "_ca_memory"}, mem_err, 0);
  endtask

  task automatic do_run(input int arg, input string tag, output int highs, output int last_high,
                        output int done_idx, output int gd);
    int g0, we_err;
    g0 = gens; highs = 0; last_high = -1; done_idx = -1; we_err = 0;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd2; bus.cmd_arg = GB'(arg);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int c = 0; c < arg + 6; c++) begin
      if (bus.ca_halt_n) begin
        highs++;
        last_high = c;
      end
      if (bus.done && done_idx < 0) done_idx = c;
      if (!bus.ca_write_enable_n) we_err++;
      @(negedge clk);
    end
    gd = gens - g0;
    chk({tag, "_we_n_high"}, we_err, 0);
  endtask

  task automatic do_read(input int stall_blk, input int stall_len, input string tag);
    int         idx, stalls, stall_err, cyc, g0;
    logic [7:0] held;
    idx = 0; stalls = 0; stall_err = 0; cyc = 0; held = 8'h00;
    g0 = gens;
    bus.rd_ready  = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd3;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    while (idx < NB && cyc < 300) begin
      bus.rd_ready = 1'b0;
      if (bus.rd_valid) begin
        if (idx == stall_blk && stalls < stall_len) begin
          if (stalls == 0) held = bus.rd_data;
          else if (bus.rd_data != held) stall_err++;
          if (int'(bus.ca_address) != idx || bus.ca_halt_n) stall_err++;
          stalls++;
        end else begin
          if (idx == stall_blk && stalls > 0 && bus.rd_data != held) stall_err++;
          rd_buf[idx]  = bus.rd_data;
          bus.rd_ready = 1'b1;
          idx++;
        end
      end
      cyc++;
      @(negedge clk);
    end
    bus.rd_ready = 1'b0;
    chk({tag, "_timeout"}, int'(cyc < 300), 1);
    chk({tag, "_done"}, int'(bus.done), 1);
    chk({tag, "_idle_busy"}, int'(bus.busy), 0);
    chk({tag, "_stall_cycles"}, stalls, stall_len);
    chk({tag, "_stall_stable"}, stall_err, 0);
    chk({tag, "_no_advance"}, gens - g0, 0);
  endtask

  int highs, last_high, done_idx, gd, errs, g_run;

  initial begin
    reset = 1'b1; model_clr = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_arg = '0;
    bus.load_valid = 1'b0; bus.load_data = 8'h00; bus.rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0; model_clr = 1'b0;

    // reset asserted mid-cycle while a LOAD is writing block 1
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1;
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.load_valid = 1'b1; bus.load_data = 8'h5A;
    @(negedge clk);
    bus.load_data = 8'hA5;
    @(posedge clk);
    #2;
    chk("t1_pre_we_n", int'(bus.ca_write_enable_n), 0);
    bus.load_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("t1_we_n", int'(bus.ca_write_enable_n), 1);
    chk("t1_halt_n", int'(bus.ca_halt_n), 0);
    chk("t1_addr", int'(bus.ca_address), 0);
    chk("t1_data_in", int'(bus.ca_data_in), 0);
    chk("t1_rd_valid", int'(bus.rd_valid), 0);
    chk("t1_rd_data", int'(bus.rd_data), 0);
    chk("t1_done", int'(bus.done), 0);
    chk("t1_busy", int'(bus.busy), 0);
    chk("t1_cmd_ready", int'(bus.cmd_ready), 1);
    chk("t1_load_ready", int'(bus.load_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    clear_model();

    // back-to-back LOAD of 0x00..0x1B
    for (int i = 0; i < NB; i++) load_buf[i] = 8'(i);
    do_load(-1, 0, "t2");

    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("nop_done", int'(bus.done), 1);
    chk("nop_busy", int'(bus.busy), 0);

    // LOAD with a 3-cycle gap after block 5
    for (int i = 0; i < NB; i++) load_buf[i] = 8'(i * 7 + 3);
    do_load(5, 3, "t3");

    do_run(5, "t4_run5", highs, last_high, done_idx, gd);
    chk("t4_run5_highs", highs, 5);
    chk("t4_run5_last_high", last_high, 4);
    chk("t4_run5_done_idx", done_idx, 6);
    chk("t4_run5_gens", gd, 5);
    do_run(0, "t4_run0", highs, last_high, done_idx, gd);
    chk("t4_run0_highs", highs, 0);
    chk("t4_run0_done_idx", done_idx, 0);
    chk("t4_run0_gens", gd, 0);

    // single live cell in block 0 reads back as 0x03 then zeros
    clear_model();
    for (int i = 0; i < NB; i++) load_buf[i] = 8'h00;
    load_buf[0] = 8'h01;
    do_load(-1, 0, "t5");
    do_read(-1, 0, "t5");
    chk("t5_blk0", int'(rd_buf[0]), 8'h03);
    errs = 0;
    for (int i = 1; i < NB; i++) if (rd_buf[i] != 8'h00) errs++;
    chk("t5_rest_zero", errs, 0);

    // READ with a 4-cycle stall on block 2
    for (int i = 0; i < NB; i++) load_buf[i] = 8'(i * 37 + 11);
    do_load(-1, 0, "t6");
    exp_img = nxt;
    do_read(2, 4, "t6");
    errs = 0;
    for (int i = 0; i < NB; i++) if (rd_buf[i] != exp_img[i*8 +: 8]) errs++;
    chk("t6_read_data", errs, 0);

    // reset in the middle of RUN 100
    g_run = gens;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd2; bus.cmd_arg = GB'(100);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6_run_halt_pre", int'(bus.ca_halt_n), 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_halt_n", int'(bus.ca_halt_n), 0);
    chk("t6_rst_busy", int'(bus.busy), 0);
    @(negedge clk);
    reset = 1'b0;
    chk("t6_gens_applied", gens - g_run, 21);
    chk("t6_gens_below_100", int'((gens - g_run) < 100), 1);
    exp_img = nxt;
    do_read(-1, 0, "t6b");
    errs = 0;
    for (int i = 0; i < NB; i++) if (rd_buf[i] != exp_img[i*8 +: 8]) errs++;
    chk("t6b_read_data", errs, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
